// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the fetch stage.
// Evaluates immediate and register branches against the {N, V, Z} flags,
// supports stall, a sticky halt, a one-cycle flush after a taken redirect
// and a saturating count of taken branches.
module pc_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter int                IMM_W    = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              hlt,
    input  logic [3:0]        B,
    input  logic [2:0]        C,
    input  logic [2:0]        F,
    input  logic [IMM_W-1:0]  I,
    input  logic [ADDR_W-1:0] branch_reg_in,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_2,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    localparam logic [3:0] OP_BR_IMM = 4'b1100;
    localparam logic [3:0] OP_BR_REG = 4'b1101;

    // Sign extension needs at least one bit beyond the immediate itself.
    localparam int EXT_W = (ADDR_W > IMM_W) ? ADDR_W : IMM_W + 1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next;
    logic              flush_next;
    logic [CNT_W-1:0]  count_next;

    logic              flag_n, flag_v, flag_z;
    logic              cond_true;
    logic              is_branch;
    logic              taken;
    logic [EXT_W-1:0]  imm_sext;
    logic [ADDR_W-1:0] imm_trunc;
    logic [ADDR_W-1:0] target_imm;

    assign flag_n = F[2];
    assign flag_v = F[1];
    assign flag_z = F[0];

    assign pc_plus_2  = pc + ADDR_W'(2);
    assign imm_sext   = {{(EXT_W-IMM_W){I[IMM_W-1]}}, I};
    assign imm_trunc  = imm_sext[ADDR_W-1:0];
    // Immediate is in halfwords, so it is doubled before the add.
    assign target_imm = pc_plus_2 + (imm_trunc << 1);

    assign is_branch = (B == OP_BR_IMM) || (B == OP_BR_REG);
    assign taken     = is_branch && cond_true;

    // Condition-code decode against the current flags.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        cond_true = 1'b0;
        case (C)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z & ~flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z | ~flag_n;
            3'b101:  cond_true = flag_z | flag_n;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // Next-state and next-value logic; reset is applied in the registers.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        flush_next = 1'b0;
        count_next = taken_count;
        // Only an accepted instruction (running, not stalled) has any effect.
        if (state == S_RUN && !stall) begin
            if (hlt) begin
                // Halt wins over a branch in the same slot; PC holds.
                state_next = S_HALT;
            end else if (taken) begin
                flush_next = 1'b1;
                if (taken_count != '1) begin
                    count_next = taken_count + CNT_W'(1);
                end
                // Register target is used verbatim, bit 0 included.
                pc_next = (B == OP_BR_IMM) ? target_imm : branch_reg_in;
            end else begin
                pc_next = pc_plus_2;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch
        // rather than in the sensitivity list.
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: PC, flush pulse, halt flag and taken counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (rst) begin
            pc          <= RESET_PC;
            flush       <= 1'b0;
            halted      <= 1'b0;
            taken_count <= '0;
        end else begin
            pc          <= pc_next;
            flush       <= flush_next;
            halted      <= (state_next == S_HALT);
            taken_count <= count_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// random stimulus, compared against a behavioural model of the PC unit.
module tb_pc_sequencer;

    localparam int ADDR_W = 16;
    localparam int IMM_W  = 9;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 2;

    logic              clk = 1'b0;
    logic              rst, stall, hlt;
    logic [3:0]        B;
    logic [2:0]        C, F;
    logic [IMM_W-1:0]  I;
    logic [ADDR_W-1:0] branch_reg_in;

    logic [ADDR_W-1:0] pc, pc_plus_2;
    logic              flush, halted;
    logic [CNT_W-1:0]  taken_count;

    logic [ADDR_W-1:0] pc_s, pc_plus_2_s;
    logic              flush_s, halted_s;
    logic [SAT_W-1:0]  taken_count_s;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int m_pc, m_cnt, m_cnt_s;
    bit m_flush, m_halt;

    pc_sequencer #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .RESET_PC(16'h0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .hlt(hlt), .B(B), .C(C), .F(F), .I(I),
        .branch_reg_in(branch_reg_in), .pc(pc), .pc_plus_2(pc_plus_2),
        .flush(flush), .halted(halted), .taken_count(taken_count)
    );

    pc_sequencer #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .RESET_PC(16'h0), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .hlt(hlt), .B(B), .C(C), .F(F), .I(I),
        .branch_reg_in(branch_reg_in), .pc(pc_s), .pc_plus_2(pc_plus_2_s),
        .flush(flush_s), .halted(halted_s), .taken_count(taken_count_s)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Branch condition from the mnemonic meanings of the condition codes.
    function automatic bit cond_model(input logic [2:0] c, input logic [2:0] f);
        bit n, v, z;
        n = f[2]; v = f[1]; z = f[0];
        case (c)
            3'd0: return !z;          // NEQ
            3'd1: return z;           // EQ
            3'd2: return !z && !n;    // GT
            3'd3: return n;           // LT
            3'd4: return z || !n;     // GEQ
            3'd5: return z || n;      // LEQ
            3'd6: return v;           // OVF
            default: return 1'b1;     // always
        endcase
    endfunction

    // Apply one cycle of inputs, advance the model, and compare all outputs.
    task automatic step(input string label, input bit r, input bit st, input bit h,
                        input logic [3:0] b, input logic [2:0] c, input logic [2:0] f,
                        input logic [IMM_W-1:0] imm, input logic [ADDR_W-1:0] breg);
        int  off;
        bit  tk;
        rst = r; stall = st; hlt = h; B = b; C = c; F = f; I = imm; branch_reg_in = breg;
        @(posedge clk);
        #1;
        tk  = ((b == 4'b1100) || (b == 4'b1101)) && cond_model(c, f);
        off = (int'(imm) >= 256) ? int'(imm) - 512 : int'(imm);
        m_flush = 1'b0;
        if (r) begin
            m_pc = 0; m_halt = 1'b0; m_cnt = 0; m_cnt_s = 0;
        end else if (m_halt || st) begin
            // frozen
        end else if (h) begin
            m_halt = 1'b1;
        end else if (tk) begin
            m_flush = 1'b1;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
            if (b == 4'b1100) m_pc = (m_pc + 2 + off * 2) & 16'hFFFF;
            else m_pc = int'(breg);
        end else begin
            m_pc = (m_pc + 2) & 16'hFFFF;
        end
        check({label, ".pc"},          32'(pc),            32'(m_pc));
        check({label, ".pc_plus_2"},   32'(pc_plus_2),     32'((m_pc + 2) & 16'hFFFF));
        check({label, ".flush"},       32'(flush),         32'(m_flush));
        check({label, ".halted"},      32'(halted),        32'(m_halt));
        check({label, ".taken_count"}, 32'(taken_count),   32'(m_cnt));
        check({label, ".sat_count"},   32'(taken_count_s), 32'(m_cnt_s));
        check({label, ".sat_pc"},      32'(pc_s),          32'(m_pc));
    endtask

    initial begin
        logic [3:0] rb;
        int sat_expect [5] = '{1, 2, 3, 3, 3};
        m_pc = 0; m_cnt = 0; m_cnt_s = 0; m_flush = 0; m_halt = 0;
        rst = 1'b1; stall = 1'b0; hlt = 1'b0; B = 4'b0; C = 3'b0; F = 3'b0;
        I = '0; branch_reg_in = '0;

        // T1: reset dominates stall, hlt and a taken branch.
        step("t1_reset", 1, 1, 1, 4'b1100, 3'b111, 3'b000, 9'h004, 16'h0000);
        check("t1_pc_const", 32'(pc), 32'h0);

        // T2: jump near the top of the address space, then wrap sequentially.
        step("t2_load", 0, 0, 0, 4'b1101, 3'b111, 3'b000, 9'h000, 16'hFFFC);
        step("t2_seq0", 0, 0, 0, 4'b0000, 3'b111, 3'b000, 9'h000, 16'h0000);
        check("t2_fffe", 32'(pc), 32'hFFFE);
        step("t2_seq1", 0, 0, 0, 4'b0000, 3'b111, 3'b000, 9'h000, 16'h0000);
        check("t2_wrap", 32'(pc), 32'h0000);
        step("t2_seq2", 0, 0, 0, 4'b0000, 3'b111, 3'b000, 9'h000, 16'h0000);
        check("t2_0002", 32'(pc), 32'h0002);

        // T3: immediate branch of -1 halfword back onto itself, then not taken.
        step("t3_load", 0, 0, 0, 4'b1101, 3'b111, 3'b000, 9'h000, 16'h0010);
        step("t3_taken", 0, 0, 0, 4'b1100, 3'b001, 3'b001, 9'h1FF, 16'h0000);
        check("t3_self", 32'(pc), 32'h0010);
        step("t3_nt", 0, 0, 0, 4'b1100, 3'b001, 3'b000, 9'h1FF, 16'h0000);
        check("t3_nt_pc", 32'(pc), 32'h0012);
        step("t3_fwd", 0, 0, 0, 4'b1100, 3'b111, 3'b000, 9'h0FF, 16'h0000);

        // T4: register branch across every condition code and flag pattern.
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                step($sformatf("t4_c%0d_f%0d", c, f), 0, 0, 0, 4'b1101, 3'(c), 3'(f),
                     9'h000, 16'h1234);
            end
        end

        // T5: stall beats a taken branch; hlt beats a taken branch and sticks.
        step("t5_stall", 0, 1, 0, 4'b1101, 3'b111, 3'b000, 9'h000, 16'h4444);
        step("t5_hlt", 0, 0, 1, 4'b1101, 3'b111, 3'b000, 9'h000, 16'h4444);
        check("t5_halted", 32'(halted), 32'h1);
        step("t5_ign0", 0, 0, 0, 4'b1101, 3'b111, 3'b000, 9'h000, 16'h5555);
        step("t5_ign1", 0, 0, 0, 4'b1100, 3'b111, 3'b000, 9'h010, 16'h0000);
        step("t5_ign2", 0, 0, 0, 4'b0000, 3'b000, 3'b000, 9'h000, 16'h0000);
        step("t5_rst", 1, 0, 1, 4'b1101, 3'b111, 3'b000, 9'h000, 16'h5555);

        // T6: five taken branches saturate the narrow counter at 3.
        for (int k = 0; k < 5; k++) begin
            step($sformatf("t6_br%0d", k), 0, 0, 0, 4'b1100, 3'b111, 3'b000, 9'h002, 16'h0000);
            check($sformatf("t6_sat%0d", k), 32'(taken_count_s), 32'(sat_expect[k]));
        end

        // Random phase: mixed stalls, halts, resets and branch kinds.
        step("rnd_rst", 1, 0, 0, 4'b0000, 3'b000, 3'b000, 9'h000, 16'h0000);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 2))
                0: rb = 4'b1100;
                1: rb = 4'b1101;
                default: begin
                    rb = 4'($urandom_range(0, 15));
                    if (rb == 4'b1100 || rb == 4'b1101) rb = 4'b0000;
                end
            endcase
            step($sformatf("rnd%0d", n),
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 99) == 0),
                 rb, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 9'($urandom_range(0, 511)), 16'($urandom_range(0, 65535)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
